// File: rtl/rv32i_iotop.sv
// rtl/rv32i_iotop.sv - memory-mapped IO responder for the rv32i data port
// Purpose : answers io_* accesses from the mem stage. It provides:
//           - a LED output register
//           - synchronised switch inputs
//           - a 64-bit cycle counter with a coherent high-word shadow
//           - a compare timer with an interrupt flag
//           - a scratch register
//           Writes are synchronous; read data is registered with a 1-cycle latency.
// Optional: IO_SW_DEBOUNCE_EN adds a per-bit debounce counter on the switch path.
// Ports   : clk        system clock
//           reset      synchronous reset, active-high
//           io_we      write enable
//           io_be      byte enables, be[n] -> wdata[8n+7:8n]
//           io_addr    word address (byte address bits [31:2])
//           io_wdata   write data
//           io_rdata   registered read data
//           sw_in      asynchronous switch inputs
//           led_out    LED register
//           timer_irq  level timer interrupt (flag & irq_en)
// CYC_RST is the cycle counter value loaded on reset. It is 0 in normal use.
module rv32i_iotop #(
   parameter int          LED_W        = 16,
   parameter int          SW_W         = 16,
   parameter int          DEBOUNCE_CNT = 50000,
   parameter logic [63:0] CYC_RST      = 64'd0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              io_we,
   input  logic [3:0]        io_be,
   input  logic [29:0]       io_addr,
   input  logic [31:0]       io_wdata,
   output logic [31:0]       io_rdata,
   input  logic [SW_W-1:0]   sw_in,
   output logic [LED_W-1:0]  led_out,
   output logic              timer_irq
);

   localparam logic [2:0] IDX_LED     = 3'd0;
   localparam logic [2:0] IDX_SW      = 3'd1;
   localparam logic [2:0] IDX_CYC_LO  = 3'd2;
   localparam logic [2:0] IDX_CYC_HI  = 3'd3;
   localparam logic [2:0] IDX_TCMP    = 3'd4;
   localparam logic [2:0] IDX_TCNT    = 3'd5;
   localparam logic [2:0] IDX_TCTRL   = 3'd6;
   localparam logic [2:0] IDX_SCRATCH = 3'd7;

   // io_addr[29] is byte address bit 31; byte address bits [30:5] must be zero.
   logic       mapped;
   logic [2:0] idx;
   logic       wr;

   assign mapped = io_addr[29] & (io_addr[28:3] == 26'd0);
   assign idx    = io_addr[2:0];
   assign wr     = io_we & mapped;

   logic [31:0] be_mask;
   assign be_mask = {{8{io_be[3]}}, {8{io_be[2]}}, {8{io_be[1]}}, {8{io_be[0]}}};

   logic [LED_W-1:0] led_reg;
   logic [LED_W-1:0] led_nxt;
   logic [31:0]      tcmp;
   logic [31:0]      tcnt;
   logic [31:0]      scratch;
   logic [31:0]      cyc_hi_shadow;
   logic [63:0]      cyc;
   logic             t_en;
   logic             t_arl;
   logic             t_flag;
   logic             t_irq_en;
   logic [SW_W-1:0]  sw_meta;
   logic [SW_W-1:0]  sw_sync;
   logic [SW_W-1:0]  sw_reg;
   logic [31:0]      led_ext;
   logic [31:0]      sw_ext;
   logic [31:0]      rd_nxt;
   logic [31:0]      tcmp_wr;
   logic [31:0]      tcnt_wr;
   logic [31:0]      scratch_wr;

   assign tcmp_wr    = (tcmp    & ~be_mask) | (io_wdata & be_mask);
   assign tcnt_wr    = (tcnt    & ~be_mask) | (io_wdata & be_mask);
   assign scratch_wr = (scratch & ~be_mask) | (io_wdata & be_mask);

   always_comb begin
      led_nxt = led_reg;
      for (int i = 0; i < LED_W; i++) begin
         if (be_mask[i]) begin
            led_nxt[i] = io_wdata[i];
         end
      end
   end

   always_comb begin
      led_ext = '0;
      for (int i = 0; i < LED_W; i++) begin
         led_ext[i] = led_reg[i];
      end
   end

   always_comb begin
      sw_ext = '0;
      for (int i = 0; i < SW_W; i++) begin
         sw_ext[i] = sw_reg[i];
      end
   end

   // Timer next-state. A software write to TCNT overrides both reload and increment.
   // Software TCTRL bits override the one-shot en clear.
   // A hit always sets the flag, even when a W1C clear arrives in the same cycle.
   logic        hit;
   logic [31:0] tcnt_nxt;
   logic        en_nxt;
   logic        arl_nxt;
   logic        flag_nxt;
   logic        irq_en_nxt;

   assign hit = t_en & (tcnt == tcmp);

   always_comb begin
      tcnt_nxt   = tcnt;
      en_nxt     = t_en;
      arl_nxt    = t_arl;
      flag_nxt   = t_flag;
      irq_en_nxt = t_irq_en;

      if (wr && idx == IDX_TCNT) begin
         tcnt_nxt = tcnt_wr;
      end else if (hit) begin
         tcnt_nxt = t_arl ? 32'd0 : tcnt;
      end else if (t_en) begin
         tcnt_nxt = tcnt + 32'd1;
      end

      if (hit && !t_arl) begin
         en_nxt = 1'b0;
      end

      if (wr && idx == IDX_TCTRL && io_be[0]) begin
         en_nxt     = io_wdata[0];
         arl_nxt    = io_wdata[1];
         irq_en_nxt = io_wdata[3];
         if (io_wdata[2]) begin
            flag_nxt = 1'b0;
         end
      end

      if (hit) begin
         flag_nxt = 1'b1;
      end
   end

   // Read mux samples current register values, so a same-cycle write returns the old value.
   always_comb begin
      rd_nxt = 32'd0;
      case (idx)
         IDX_LED:     rd_nxt = led_ext;
         IDX_SW:      rd_nxt = sw_ext;
         IDX_CYC_LO:  rd_nxt = cyc[31:0];
         IDX_CYC_HI:  rd_nxt = cyc_hi_shadow;
         IDX_TCMP:    rd_nxt = tcmp;
         IDX_TCNT:    rd_nxt = tcnt;
         IDX_TCTRL:   rd_nxt = {28'd0, t_irq_en, t_flag, t_arl, t_en};
         IDX_SCRATCH: rd_nxt = scratch;
         default:     rd_nxt = 32'd0;
      endcase
      if (!mapped) begin
         rd_nxt = 32'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         led_reg       <= '0;
         tcmp          <= 32'd0;
         tcnt          <= 32'd0;
         scratch       <= 32'd0;
         cyc           <= CYC_RST;
         cyc_hi_shadow <= 32'd0;
         t_en          <= 1'b0;
         t_arl         <= 1'b0;
         t_flag        <= 1'b0;
         t_irq_en      <= 1'b0;
         io_rdata      <= 32'd0;
      end else begin
         cyc <= cyc + 64'd1;
         // Latching the high word alongside a CYC_LO read makes LO-then-HI a coherent pair.
         if (mapped && idx == IDX_CYC_LO) begin
            cyc_hi_shadow <= cyc[63:32];
         end
         if (wr && idx == IDX_LED) begin
            led_reg <= led_nxt;
         end
         if (wr && idx == IDX_TCMP) begin
            tcmp <= tcmp_wr;
         end
         if (wr && idx == IDX_SCRATCH) begin
            scratch <= scratch_wr;
         end
         tcnt     <= tcnt_nxt;
         t_en     <= en_nxt;
         t_arl    <= arl_nxt;
         t_flag   <= flag_nxt;
         t_irq_en <= irq_en_nxt;
         io_rdata <= rd_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= sw_in;
         sw_sync <= sw_meta;
      end
   end

`ifdef IO_SW_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CNT + 1);

   logic [CW-1:0] deb_cnt [SW_W];

   // Each bit counts consecutive cycles of disagreement with the accepted value.
   // Agreement restarts the count.
   always_ff @(posedge clk) begin
      if (reset) begin
         sw_reg <= '0;
         for (int i = 0; i < SW_W; i++) begin
            deb_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < SW_W; i++) begin
            if (sw_sync[i] == sw_reg[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == CW'(DEBOUNCE_CNT - 1)) begin
               sw_reg[i]  <= sw_sync[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + CW'(1);
            end
         end
      end
   end
`else
   assign sw_reg = sw_sync;
`endif

   assign led_out   = led_reg;
   assign timer_irq = t_flag & t_irq_en;

endmodule
